// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan decoder: controller state encoding
// and a width-generic one-hot encoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam int MAX_ADDR_WIDTH = 8;
    localparam int MAX_OUTPUTS    = 1 << MAX_ADDR_WIDTH;

    // Callers zero-extend their address to MAX_ADDR_WIDTH and keep the low 2^W bits.
    function automatic logic [MAX_OUTPUTS-1:0] onehot(input logic [MAX_ADDR_WIDTH-1:0] addr);
        onehot = {{(MAX_OUTPUTS-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational ADDR_WIDTH-to-2^ADDR_WIDTH one-hot decoder with enable.
// All outputs are low when en is low.
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter  int ADDR_WIDTH = 2,
    localparam int OUTPUTS    = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    output logic [OUTPUTS-1:0]    dec
);

    logic [MAX_OUTPUTS-1:0] full_s;

    assign full_s = onehot(MAX_ADDR_WIDTH'(addr));

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_width
        $error("onehot_decoder: ADDR_WIDTH out of supported range");
    end

    if (OUTPUTS < MAX_OUTPUTS) begin : g_pad
        logic unused_pad_s;
        assign unused_pad_s = |full_s[MAX_OUTPUTS-1:OUTPUTS];
    end

    // Gate the decoded line with the enable.
    always_comb begin
        dec = {OUTPUTS{1'b0}};
        if (en) begin
            dec = full_s[OUTPUTS-1:0];
        end else begin
            dec = {OUTPUTS{1'b0}};
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select with an address register and an auto-increment
// scan mode; out, wrapped and cur_address all update on the rising edge.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter  int ADDR_WIDTH = 2,
    localparam int OUTPUTS    = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  scan,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [OUTPUTS-1:0]    out,
    output logic [ADDR_WIDTH-1:0] cur_address,
    output logic                  wrapped,
    output logic                  busy
);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   cur_address_r;
    logic [ADDR_WIDTH-1:0]   addr_nxt_s;
    logic [OUTPUTS-1:0]      out_r;
    logic [OUTPUTS-1:0]      dec_s;
    logic                    wrapped_r;
    logic                    wrap_nxt_s;
    logic                    dec_en_s;

    // Next state and next address; clear beats load, load beats scan.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = cur_address_r;
        wrap_nxt_s  = 1'b0;
        if (clear) begin
            state_nxt_s = IDLE;
        end else if (load) begin
            addr_nxt_s  = address;
            state_nxt_s = scan ? SCAN : ACTIVE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ACTIVE: begin
                    state_nxt_s = scan ? SCAN : ACTIVE;
                end
                SCAN: begin
                    if (!scan) begin
                        state_nxt_s = ACTIVE;
                    end else if (enable) begin
                        addr_nxt_s = cur_address_r + ADDR_WIDTH'(1);
                        wrap_nxt_s = (cur_address_r == {ADDR_WIDTH{1'b1}});
                    end else begin
                        addr_nxt_s = cur_address_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign dec_en_s = enable && (state_nxt_s != IDLE);

    onehot_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dec (
        .addr (addr_nxt_s),
        .en   (dec_en_s),
        .dec  (dec_s)
    );

    // State, address, select and wrap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cur_address_r <= {ADDR_WIDTH{1'b0}};
            out_r         <= {OUTPUTS{1'b0}};
            wrapped_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cur_address_r <= addr_nxt_s;
            out_r         <= dec_s;
            wrapped_r     <= wrap_nxt_s;
        end
    end

    assign out         = out_r;
    assign cur_address = cur_address_r;
    assign wrapped     = wrapped_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: directed vector table on a 2-bit instance, a 3-bit
// sweep, and randomized traffic checked against an abstract reference model.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0, enable = 1'b0, clear = 1'b0, load = 1'b0, scan = 1'b0;
    logic [1:0] address2 = 2'd0;
    logic [2:0] address3 = 3'd0;
    logic [3:0] out2;
    logic [1:0] cur2;
    logic       wr2, busy2;
    logic [7:0] out3;
    logic [2:0] cur3;
    logic       wr3, busy3;

    int ntests = 0;
    int nfail  = 0;

    // reference model: 0 = idle, 1 = active, 2 = scan
    int m_st[2];
    int m_a[2];
    int m_w[2];
    int m_o[2];

    always #5 clk = ~clk;

    scan_decoder #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .scan(scan), .address(address2), .out(out2), .cur_address(cur2),
        .wrapped(wr2), .busy(busy2)
    );

    scan_decoder #(.ADDR_WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .scan(scan), .address(address3), .out(out3), .cur_address(cur3),
        .wrapped(wr3), .busy(busy3)
    );

    typedef struct {
        bit   r, e, c, l, s;
        int   a;
        logic [3:0] eo;
        int   ec;
        bit   ew, eb;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input bit r, e, c, l, s, input int a,
                        input logic [3:0] eo, input int ec, input bit ew, eb);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.l = l; v.s = s; v.a = a;
        v.eo = eo; v.ec = ec; v.ew = ew; v.eb = eb;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            int ain;
            n   = (k == 0) ? 4 : 8;
            ain = (k == 0) ? int'(address2) : int'(address3);
            if (reset) begin
                m_st[k] = 0; m_a[k] = 0; m_w[k] = 0;
            end else begin
                m_w[k] = 0;
                if (clear) begin
                    m_st[k] = 0;
                end else if (load) begin
                    m_a[k]  = ain % n;
                    m_st[k] = scan ? 2 : 1;
                end else if (m_st[k] == 1 && scan) begin
                    m_st[k] = 2;
                end else if (m_st[k] == 2) begin
                    if (!scan) m_st[k] = 1;
                    else if (enable) begin
                        m_w[k] = (m_a[k] == n - 1) ? 1 : 0;
                        m_a[k] = (m_a[k] + 1) % n;
                    end
                end
            end
            m_o[k] = (!reset && m_st[k] != 0 && enable) ? (1 << m_a[k]) : 0;
        end
    endtask

    task automatic check_model();
        chk("m2_out",  32'(out2),  32'(m_o[0]));
        chk("m2_cur",  32'(cur2),  32'(m_a[0]));
        chk("m2_wrap", 32'(wr2),   32'(m_w[0]));
        chk("m2_busy", 32'(busy2), 32'(m_st[0] != 0));
        chk("m3_out",  32'(out3),  32'(m_o[1]));
        chk("m3_cur",  32'(cur3),  32'(m_a[1]));
        chk("m3_wrap", 32'(wr3),   32'(m_w[1]));
        chk("m3_busy", 32'(busy3), 32'(m_st[1] != 0));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drive(input bit r, e, c, l, s, input int a2, input int a3);
        reset = r; enable = e; clear = c; load = l; scan = s;
        address2 = 2'(a2); address3 = 3'(a3);
    endtask

    initial begin
        int wraps;
        m_st = '{0, 0}; m_a = '{0, 0}; m_w = '{0, 0}; m_o = '{0, 0};

        //    r  e  c  l  s  a  out      cur w  b
        addv(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        addv(0, 1, 0, 0, 1, 0, 4'b0000, 0, 0, 0);   // scan alone ignored in idle
        addv(0, 1, 0, 1, 0, 2, 4'b0100, 2, 0, 1);
        for (int en = 0; en < 2; en++)
            for (int a = 0; a < 4; a++)
                addv(0, bit'(en), 0, 1, 0, a, (en != 0) ? 4'(1 << a) : 4'b0000, a, 0, 1);
        addv(0, 1, 0, 1, 1, 2, 4'b0100, 2, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b1000, 3, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b0001, 0, 1, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b0010, 1, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b0100, 2, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 4'b0000, 2, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 4'b0000, 2, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 4'b0000, 2, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b1000, 3, 0, 1);
        addv(0, 1, 1, 1, 1, 1, 4'b0000, 3, 0, 0);   // clear beats load
        addv(0, 1, 0, 1, 1, 1, 4'b0010, 1, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b0100, 2, 0, 1);
        addv(1, 1, 0, 1, 1, 3, 4'b0000, 0, 0, 0);   // reset mid-scan
        addv(0, 1, 0, 1, 0, 3, 4'b1000, 3, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 4'b0000, 3, 0, 1);   // enable gates out only
        addv(0, 1, 0, 0, 0, 0, 4'b1000, 3, 0, 1);
        addv(0, 1, 0, 0, 1, 0, 4'b1000, 3, 0, 1);   // active -> scan, no increment
        addv(0, 1, 0, 0, 1, 0, 4'b0001, 0, 1, 1);
        addv(0, 1, 0, 0, 0, 0, 4'b0001, 0, 0, 1);   // scan -> active, held

        @(negedge clk);
        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].e, vq[i].c, vq[i].l, vq[i].s, vq[i].a, 0);
            cyc();
            chk($sformatf("v%0d_out", i),  32'(out2),  32'(vq[i].eo));
            chk($sformatf("v%0d_cur", i),  32'(cur2),  32'(vq[i].ec));
            chk($sformatf("v%0d_wrap", i), 32'(wr2),   32'(vq[i].ew));
            chk($sformatf("v%0d_busy", i), 32'(busy2), 32'(vq[i].eb));
        end

        // 3-bit instance: reset mid-scan, then a full sweep with one wrap
        drive(0, 1, 0, 1, 1, 0, 5);
        cyc();
        drive(0, 1, 0, 0, 1, 0, 0);
        cyc();
        drive(1, 1, 0, 1, 1, 0, 4);
        cyc();
        chk("aw3_rst_cur", 32'(cur3), 32'd0);
        chk("aw3_rst_out", 32'(out3), 32'd0);
        chk("aw3_rst_busy", 32'(busy3), 32'd0);
        drive(0, 1, 0, 1, 1, 0, 0);
        cyc();
        chk("aw3_start", 32'(out3), 32'h01);
        wraps = 0;
        drive(0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (wr3) wraps++;
            chk($sformatf("aw3_sweep%0d", i), 32'(out3), 32'(1 << ((i + 1) % 8)));
        end
        chk("aw3_wraps", 32'(wraps), 32'd1);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7));
            cyc();
            chk("onehot2", 32'($countones(out2) <= 1), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
